// File: rtl/td4_board_io.sv
// TD4 board shell: run/step clock-enable, step debounce, muxed 7-seg scan.
// In: CLK_I, RESET_N_I, MODE_I, STEP_I, DISP_I, DP_I. Out: TD4_CE_O, STEP_DB_O, SEG_O, DIG_EN_O.

module td4_board_io #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEB_CYC     = 500_000,
  parameter int NDIG        = 4,
  parameter int DWELL_CYC   = 12_500,
  parameter int BLANK_CYC   = 64,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic              CLK_I,
  input  logic              RESET_N_I,
  input  logic              MODE_I,
  input  logic              STEP_I,
  input  logic [4*NDIG-1:0] DISP_I,
  input  logic [NDIG-1:0]   DP_I,
  output logic              TD4_CE_O,
  output logic              STEP_DB_O,
  output logic [7:0]        SEG_O,
  output logic [NDIG-1:0]   DIG_EN_O
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DVW = $clog2(DIV);
  localparam int DBW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int SCW = $clog2(DWELL_CYC);
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [DVW-1:0]  DIV_MAX = DVW'(DIV - 1);
  localparam logic [DBW-1:0]  DB_MAX  = DBW'(DEB_CYC - 1);
  localparam logic [SCW-1:0]  BL_MAX  = SCW'(BLANK_CYC - 1);
  localparam logic [SCW-1:0]  SH_MAX  = SCW'(DWELL_CYC - BLANK_CYC - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
  localparam logic [7:0]      SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [NDIG-1:0] DIG_OFF = {NDIG{SEG_ACT_LOW}};

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_t;

  function automatic logic [6:0] font(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic           mode_s1, mode_s2, mode_q;
  logic           step_s1, step_s2;
  logic           db_q, db_prev, ce_q;
  logic [DVW-1:0] div_cnt;
  logic [DBW-1:0] db_cnt;
  logic           mode_chg, tick, db_diff, db_hit, db_rise;

  assign mode_chg = mode_s2 ^ mode_q;
  assign tick     = ~mode_chg & (div_cnt == DIV_MAX);
  assign db_diff  = step_s2 ^ db_q;
  assign db_hit   = db_diff & (db_cnt == DB_MAX);
  // a rise coinciding with a mode switch is dropped so CE never doubles up
  assign db_rise  = db_q & ~db_prev & ~mode_chg;

  always_ff @(posedge CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      div_cnt <= '0;
      db_cnt  <= '0;
      db_q    <= 1'b0;
      db_prev <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      mode_s1 <= MODE_I;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
      step_s1 <= STEP_I;
      step_s2 <= step_s1;
      div_cnt <= (mode_chg | tick) ? '0 : div_cnt + 1'b1;
      if (!db_diff || db_hit) db_cnt <= '0;
      else                    db_cnt <= db_cnt + 1'b1;
      if (db_hit) db_q <= ~db_q;
      db_prev <= db_q;
      ce_q    <= mode_s2 ? db_rise : tick;
    end
  end

  scan_t           st, st_n;
  logic [SCW-1:0]  sc_cnt, sc_cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            prime, load;
  logic [3:0]      nib;
  logic [7:0]      seg_q, seg_n;
  logic [NDIG-1:0] dig_q, dig_n;

  // prime loads digit 0 in the first cycle after reset, since
  // reset does not pass through a SHOW->BLANK transition
  always_comb begin
    st_n     = st;
    sc_cnt_n = sc_cnt + 1'b1;
    idx_n    = idx;
    load     = prime;
    unique case (st)
      BLANK: begin
        if (sc_cnt == BL_MAX) begin
          st_n     = SHOW;
          sc_cnt_n = '0;
        end
      end
      SHOW: begin
        if (sc_cnt == SH_MAX) begin
          st_n     = BLANK;
          sc_cnt_n = '0;
          idx_n    = (idx == IDX_MAX) ? '0 : idx + 1'b1;
          load     = 1'b1;
        end
      end
      default: ;
    endcase
    nib   = DISP_I[4*int'(idx_n) +: 4];
    seg_n = load ? ({DP_I[idx_n], font(nib)} ^ SEG_OFF) : seg_q;
    dig_n = DIG_OFF;
    if (st_n == SHOW) dig_n = (NDIG'(1) << idx_n) ^ DIG_OFF;
  end

  always_ff @(posedge CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      st     <= BLANK;
      sc_cnt <= '0;
      idx    <= '0;
      prime  <= 1'b1;
      seg_q  <= SEG_OFF;
      dig_q  <= DIG_OFF;
    end else begin
      st     <= st_n;
      sc_cnt <= sc_cnt_n;
      idx    <= idx_n;
      prime  <= 1'b0;
      seg_q  <= seg_n;
      dig_q  <= dig_n;
    end
  end

  assign TD4_CE_O  = ce_q;
  assign STEP_DB_O = db_q;
  assign SEG_O     = seg_q;
  assign DIG_EN_O  = dig_q;

endmodule

// File: tb/tb_td4_board_io.sv
// Bench for td4_board_io: cycle model + directed literal checks + random stimulus.
// Model indexes cycles from reset release; compared on every falling edge.

module tb_td4_board_io;

  localparam int DIV  = 10;
  localparam int DEB  = 4;
  localparam int ND   = 4;
  localparam int DW   = 8;
  localparam int BL   = 2;
  localparam int MAXN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] disp = 16'hA50F;
  logic [3:0]  dp = 4'b0010;
  logic        ce, db;
  logic [7:0]  seg;
  logic [3:0]  dig;

  always #5 clk = ~clk;

  td4_board_io #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEB_CYC(DEB), .NDIG(ND),
    .DWELL_CYC(DW), .BLANK_CYC(BL), .SEG_ACT_LOW(1'b1)
  ) dut (
    .CLK_I(clk), .RESET_N_I(rst_n), .MODE_I(mode), .STEP_I(step),
    .DISP_I(disp), .DP_I(dp), .TD4_CE_O(ce), .STEP_DB_O(db),
    .SEG_O(seg), .DIG_EN_O(dig)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // segment letters a..g map to bits 0..6
  function automatic logic [6:0] font_m(input logic [3:0] h);
    string s;
    logic [6:0] r;
    r = '0;
    case (h)
      4'h0: s = "abcdef";  4'h1: s = "bc";
      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";
      4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";
      4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";
      4'hE: s = "adefg";   default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  bit          rawm [MAXN];
  bit          raws [MAXN];
  bit          s2m  [MAXN];
  bit          s2s  [MAXN];
  bit          dbm  [MAXN];
  bit          cem  [MAXN];
  logic [15:0] disph [MAXN];
  logic [3:0]  dph   [MAXN];
  int          n = 0;
  int          lastclr = -1;

  // cycle n = interval after the n-th rising edge since release
  always @(posedge clk) begin
    int m, ph;
    bit clr, tk, rs, ok;
    if (!rst_n) begin
      n = 0;
      lastclr = -1;
      s2m[0] = 0; s2s[0] = 0; dbm[0] = 0; cem[0] = 0;
    end else if (n < MAXN - 1) begin
      rawm[n] = mode; raws[n] = step; disph[n] = disp; dph[n] = dp;
      m = n + 1;
      s2m[m] = (m >= 2) ? rawm[m-2] : 1'b0;
      s2s[m] = (m >= 2) ? raws[m-2] : 1'b0;
      clr = (n >= 1) && (s2m[n] != s2m[n-1]);
      if (clr) lastclr = n;
      ph = (lastclr < 0) ? n % DIV : (n - lastclr - 1) % DIV;
      tk = !clr && (ph == DIV - 1);
      rs = (n >= 1) && dbm[n] && !dbm[n-1] && !clr;
      cem[m] = s2m[n] ? rs : tk;
      ok = (m - DEB >= 0);
      if (ok)
        for (int j = m - DEB; j < m; j++)
          if (s2s[j] == dbm[j] || dbm[j] != dbm[m-1]) ok = 0;
      dbm[m] = ok ? !dbm[m-1] : dbm[m-1];
      n = m;
    end
  end

  always @(negedge clk) begin
    logic [7:0] es;
    logic [3:0] ed;
    int p, k, ix, L;
    if (!rst_n) begin
      chk("rst_ce", {31'b0, ce}, 0);
      chk("rst_db", {31'b0, db}, 0);
      chk("rst_seg", {24'b0, seg}, 32'hFF);
      chk("rst_dig", {28'b0, dig}, 32'hF);
    end else begin
      p = n % DW; k = n / DW; ix = k % ND;
      ed = (p >= BL) ? ~(4'b0001 << ix) : 4'hF;
      if (n == 0) es = 8'hFF;
      else begin
        L = (k == 0) ? 0 : k * DW - 1;
        es = ~{dph[L][ix], font_m(disph[L][4*ix +: 4])};
      end
      chk("ce", {31'b0, ce}, {31'b0, cem[n]});
      chk("db", {31'b0, db}, {31'b0, dbm[n]});
      chk("seg", {24'b0, seg}, {24'b0, es});
      chk("dig", {28'b0, dig}, {28'b0, ed});
    end
  end

  int pulses, first, last, badgap, pos, early;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // RUN from reset: CE at cycles 10,20,..,100
    pulses = 0; first = -1; last = -1; badgap = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ce) begin
        pulses++;
        if (first < 0) first = c;
        if (last >= 0 && c - last != 10) badgap++;
        last = c;
      end
      if (c == 1) chk("lit_seg_blank", {24'b0, seg}, 32'h8E);
      if (c == 1) chk("lit_dig_blank", {28'b0, dig}, 32'hF);
      if (c == 2) chk("lit_dig0", {28'b0, dig}, 32'hE);
      if (c == 2) chk("lit_segF", {24'b0, seg}, 32'h8E);
      if (c == 10) chk("lit_dig1", {28'b0, dig}, 32'hD);
      if (c == 10) chk("lit_seg0dp", {24'b0, seg}, 32'h40);
      if (c == 26) chk("lit_dig3", {28'b0, dig}, 32'h7);
      if (c == 34) chk("lit_wrap", {28'b0, dig}, 32'hE);
    end
    chk("run_pulses", pulses, 10);
    chk("run_first", first, 10);
    chk("run_gap", badgap, 0);

    // STEP: bouncing press, one CE at DEB+3 after the last rise
    mode = 1'b1;
    repeat (5) @(negedge clk);
    step = 1'b1; repeat (2) @(negedge clk);
    step = 1'b0; repeat (2) @(negedge clk);
    step = 1'b1;
    pulses = 0; pos = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce) begin pulses++; pos = i; end
    end
    chk("step_pulses", pulses, 1);
    chk("step_pos", pos, DEB + 3);
    step = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce) pulses++;
    end
    chk("release_pulses", pulses, 0);

    // RUN -> STEP -> RUN: CE 12 cycles after first sync stage sees it
    mode = 1'b0;
    repeat (15) @(negedge clk);
    mode = 1'b1;
    repeat (3) @(negedge clk);
    mode = 1'b0;
    early = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i < 13 && ce) early++;
      if (i == 13) chk("mode_first_ce", {31'b0, ce}, 1);
    end
    chk("mode_early_ce", early, 0);

    // reset mid-SHOW with a press still being debounced
    mode = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16 && (n % DW) != 4; i++) @(negedge clk);
    step = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", {24'b0, seg}, 32'hFF);
    chk("arst_dig", {28'b0, dig}, 32'hF);
    chk("arst_ce", {31'b0, ce}, 0);
    step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ce) pulses++;
      if (i == 2) chk("arst_idx0", {28'b0, dig}, 32'hE);
    end
    chk("arst_no_stale", pulses, 0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(199) == 0) mode = ~mode;
      if ($urandom_range(14) == 0) step = ~step;
      else if ($urandom_range(9) == 0) step = 1'($urandom);
      if ($urandom_range(19) == 0) disp = 16'($urandom);
      if ($urandom_range(19) == 0) dp = 4'($urandom);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
